// File: rtl/pc_stack_seq.sv
// Fetch-stage program counter with relative branch, jump, skip, stall and a
// DEPTH-entry return-address stack. Optional PC bounds check: `PC_BOUNDS_EN`.
module pc_stack_seq #(
  parameter int           D        = 12,
  parameter int           OFF_W    = 8,
  parameter int           DEPTH    = 4,
  parameter logic [D-1:0] RST_VEC  = '0,
  parameter int           MAX_ADDR = 2**D-1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       skip_en,
  input  logic                       branch_en,
  input  logic [OFF_W-1:0]           offset,
  input  logic                       jump_en,
  input  logic                       call_en,
  input  logic                       ret_en,
  input  logic [D-1:0]               target,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stk_empty,
  output logic                       stk_full,
  output logic                       stk_err,
  output logic                       halt
);
  localparam int SPW  = $clog2(DEPTH+1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef struct packed {
    logic ret;
    logic call;
    logic jump;
    logic branch;
    logic skip;
  } req_t;

  req_t            req;
  logic [D-1:0]    pc_q, pc_d, pc_n, pc_inc, off_sx;
  logic [SPW-1:0]  sp_q, sp_d, sp_n;
  logic            err_q, err_d, err_n;
  logic            push_n, push;
  logic [IDXW-1:0] wr_idx, rd_idx;
  logic [D-1:0]    stk_q [DEPTH];

  assign req    = '{ret: ret_en, call: call_en, jump: jump_en,
                    branch: branch_en, skip: skip_en};
  assign pc_inc = pc_q + 1'b1;
  assign off_sx = D'($signed(offset));
  assign wr_idx = IDXW'(sp_q);
  assign rd_idx = IDXW'(sp_q - 1'b1);

  // Candidate next state, resolved by request priority before stall/halt gating.
  always_comb begin
    pc_n   = pc_inc;
    sp_n   = sp_q;
    err_n  = err_q;
    push_n = 1'b0;
    if (req.ret) begin
      if (sp_q == '0) begin
        err_n = 1'b1;
      end else begin
        pc_n = stk_q[rd_idx];
        sp_n = sp_q - 1'b1;
      end
    end else if (req.call) begin
      pc_n = target;
      if (sp_q == SP_FULL) begin
        err_n = 1'b1;
      end else begin
        push_n = 1'b1;
        sp_n   = sp_q + 1'b1;
      end
    end else if (req.jump) begin
      pc_n = target;
    end else if (req.branch) begin
      pc_n = pc_q + off_sx;
    end else if (req.skip) begin
      pc_n = pc_q + 2'd2;
    end
  end

`ifdef PC_BOUNDS_EN
  localparam logic [D-1:0] LAST = MAX_ADDR[D-1:0];
  logic halt_q, halt_d;

  // An out-of-range target freezes everything; only reset recovers.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    err_d  = err_q;
    halt_d = halt_q;
    push   = 1'b0;
    if (!stall && !halt_q) begin
      if (pc_n > LAST) begin
        halt_d = 1'b1;
      end else begin
        pc_d  = pc_n;
        sp_d  = sp_n;
        err_d = err_n;
        push  = push_n;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) halt_q <= 1'b0;
    else          halt_q <= halt_d;
  end

  assign halt = halt_q;
`else
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (!stall) begin
      pc_d  = pc_n;
      sp_d  = sp_n;
      err_d = err_n;
      push  = push_n;
    end
  end

  assign halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RST_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stk_q[wr_idx] <= pc_inc;
  end

  assign prog_ctr  = pc_q;
  assign sp        = sp_q;
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_err   = err_q;
endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed table-driven bench for pc_stack_seq (D=12, OFF_W=8, DEPTH=4).
module tb_pc_stack_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, skip_en, branch_en, jump_en, call_en, ret_en;
  logic [7:0]  offset;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic [2:0]  sp;
  logic        stk_empty, stk_full, stk_err, halt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_stack_seq #(.D(12), .OFF_W(8), .DEPTH(4), .RST_VEC(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .skip_en(skip_en),
    .branch_en(branch_en), .offset(offset), .jump_en(jump_en),
    .call_en(call_en), .ret_en(ret_en), .target(target),
    .prog_ctr(prog_ctr), .sp(sp), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_err(stk_err), .halt(halt)
  );

`ifdef PC_BOUNDS_EN
  logic [11:0] b_pc;
  logic [2:0]  b_sp;
  logic        b_empty, b_full, b_err, b_halt;
  pc_stack_seq #(.D(12), .OFF_W(8), .DEPTH(4), .RST_VEC(12'h000),
                 .MAX_ADDR(100)) u_bnd (
    .clk(clk), .reset_n(reset_n), .stall(stall), .skip_en(skip_en),
    .branch_en(branch_en), .offset(offset), .jump_en(jump_en),
    .call_en(call_en), .ret_en(ret_en), .target(target),
    .prog_ctr(b_pc), .sp(b_sp), .stk_empty(b_empty), .stk_full(b_full),
    .stk_err(b_err), .halt(b_halt)
  );
`endif

  typedef struct {
    logic        stl, ret, call, jmp, br, skp;
    logic [7:0]  off;
    logic [11:0] tgt;
    logic [11:0] pc;
    int          sp;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic stl, logic ret, logic call, logic jmp,
                              logic br, logic skp, logic [7:0] off,
                              logic [11:0] tgt, logic [11:0] pc, int spv,
                              logic err);
    vec_t v;
    v.stl = stl; v.ret = ret; v.call = call; v.jmp = jmp; v.br = br;
    v.skp = skp; v.off = off; v.tgt = tgt; v.pc = pc; v.sp = spv; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle();
    stall = 0; skip_en = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
    offset = 8'h00; target = 12'h000;
  endtask

  initial begin
    //          stl ret cal jmp br skp off    tgt      pc       sp err
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'd1,   0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'd2,   0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'd3,   0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'd4,   0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'd5,   0, 0));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 12'd0,   12'd7,   0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 8'hFD, 12'd0,   12'd4,   0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00, 12'hFFF, 12'hFFF, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 12'd0,   12'h000, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 8'h00, 12'd0,   12'h000, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00, 12'hFFF, 12'hFFF, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 12'd0,   12'h001, 0, 0));
    vecs.push_back(mk(0,0,0,1,1,1, 8'h05, 12'h040, 12'h040, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,1, 8'h05, 12'd0,   12'h045, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00, 12'd10,  12'd10,  0, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd20,  12'd20,  1, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd30,  12'd30,  2, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd40,  12'd40,  3, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd50,  12'd50,  4, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd41,  3, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd31,  2, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd21,  1, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd11,  0, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd100, 12'd100, 1, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd200, 12'd200, 2, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd300, 12'd300, 3, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd400, 12'd400, 4, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'd500, 12'd500, 4, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd301, 3, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd201, 2, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd101, 1, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd12,  0, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd13,  0, 1));
    vecs.push_back(mk(0,0,1,1,1,0, 8'h05, 12'h123, 12'h123, 1, 1));
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00, 12'd0,   12'h123, 1, 1));
    vecs.push_back(mk(1,0,1,1,0,0, 8'h00, 12'h777, 12'h123, 1, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'd14,  0, 1));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'h200, 12'h200, 1, 1));
    vecs.push_back(mk(0,1,1,0,0,0, 8'h00, 12'h300, 12'd15,  0, 1));
    vecs.push_back(mk(0,0,0,0,1,0, 8'h80, 12'd0,   12'hF8F, 0, 1));
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00, 12'hFFF, 12'hFFF, 0, 1));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'h010, 12'h010, 1, 1));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 12'd0,   12'h000, 0, 1));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h00, 12'h055, 12'h055, 1, 1));

    idle();
    reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", prog_ctr, 0);
    chk("rst_sp", sp, 0);
    chk("rst_empty", stk_empty, 1);
    chk("rst_full", stk_full, 0);
    chk("rst_err", stk_err, 0);
    chk("rst_halt", halt, 0);
    reset_n = 1;

    foreach (vecs[i]) begin
      stall = vecs[i].stl; ret_en = vecs[i].ret; call_en = vecs[i].call;
      jump_en = vecs[i].jmp; branch_en = vecs[i].br; skip_en = vecs[i].skp;
      offset = vecs[i].off; target = vecs[i].tgt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), prog_ctr, vecs[i].pc);
      chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
      chk($sformatf("v%0d_err", i), stk_err, vecs[i].err);
      chk($sformatf("v%0d_full", i), stk_full, (vecs[i].sp == 4) ? 1 : 0);
      chk($sformatf("v%0d_empty", i), stk_empty, (vecs[i].sp == 0) ? 1 : 0);
      @(negedge clk);
    end

    // Async reset between edges, with a live stack and sticky error.
    idle();
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    chk("async_pc", prog_ctr, 0);
    chk("async_sp", sp, 0);
    chk("async_err", stk_err, 0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_pc", prog_ctr, 1);
    chk("post_rst_sp", sp, 0);
    @(negedge clk);

`ifdef PC_BOUNDS_EN
    jump_en = 1; target = 12'd101;
    @(posedge clk); #1;
    chk("bnd_hold_pc", b_pc, 1);
    chk("bnd_halt", b_halt, 1);
    @(negedge clk);
    target = 12'd5;
    @(posedge clk); #1;
    chk("bnd_ignored_pc", b_pc, 1);
    chk("bnd_halt_sticky", b_halt, 1);
    @(negedge clk);
    idle();
    reset_n = 0;
    #1;
    chk("bnd_rst_halt", b_halt, 0);
    chk("bnd_rst_pc", b_pc, 0);
    @(negedge clk);
    reset_n = 1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
